branch_predictor_bht: RTL and testbench

Parametrised successor to the single-entry branch predictor. It provides a direct-mapped branch target buffer with N-bit saturating direction counters, looked up every fetch cycle with the current PC and trained from the Execute stage. It sits beside the fetch PC mux and drives BranchPredicted and the predicted target that feed PCSrcSelect. It also flags mispredictions and keeps saturating performance counters.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/branch_predictor_bht_if.sv | 29 ++
 rtl/sat_counter.sv | 34 +++
 rtl/branch_predictor_bht.sv | 152 +++++++++++++++
 tb/tb_branch_predictor_bht.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the branch target buffer: counter reset/allocate values
// and the PC index/tag split.
package bp_pkg;

  localparam int BP_MAX_IDX_W = 8;

  // Weakly-taken value, used when a taken branch allocates an entry.
  function automatic int cnt_weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken value, used on reset.
  function automatic int cnt_weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic logic [BP_MAX_IDX_W-1:0] bp_index(input logic [63:0] pc, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return BP_MAX_IDX_W'((pc >> 2) & mask);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch lookup, Execute training and statistics signals of the branch predictor.
interface branch_predictor_bht_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic              flush_bp;
  logic [ADDR_W-1:0] currentPC;
  logic              BranchPredicted;
  logic [ADDR_W-1:0] currentBTA;
  logic              hit;
  logic              BranchE;
  logic              BranchPredictedE;
  logic              BranchTakenE;
  logic [ADDR_W-1:0] BranchPCE;
  logic [ADDR_W-1:0] ALUResultE;
  logic              mispredictE;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  modport master (
    output flush_bp, currentPC, BranchE, BranchPredictedE, BranchTakenE, BranchPCE, ALUResultE,
    input  BranchPredicted, currentBTA, hit, mispredictE, branch_cnt, mispred_cnt
  );

  modport slave (
    input  flush_bp, currentPC, BranchE, BranchPredictedE, BranchTakenE, BranchPCE, ALUResultE,
    output BranchPredicted, currentBTA, hit, mispredictE, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter with a synchronous load; load beats inc beats dec.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_max, sat_min;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sat_max = &cnt_q;
    sat_min = ~|cnt_q;
    cnt_d   = cnt_q;
    if (load)                cnt_d = load_val;
    else if (inc && !sat_max) cnt_d = cnt_q + 1'b1;
    else if (dec && !sat_min) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with saturating direction counters and misprediction stats.
// Optional BP_GSHARE_EN: counters indexed by PC index XOR a global history register.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = ADDR_W - $clog2(ENTRIES) - 2,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_bht_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_val  [ENTRIES];
  logic [ENTRIES-1:0] cnt_inc, cnt_dec, cnt_load;

  logic [IDX_W-1:0]  lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;
  logic [ADDR_W-1:0] up_target;
  entry_t            lk_e;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  always_comb ghr_d = bp.BranchE ? IDX_W'({ghr_q, bp.BranchTakenE}) : ghr_q;

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`endif

  // Two read ports: lookup from fetch PC, update from the Execute branch PC.
  always_comb begin
    lk_idx = IDX_W'(bp_index(64'(bp.currentPC), IDX_W));
    lk_tag = TAG_W'(bp_tag(64'(bp.currentPC), IDX_W));
    up_idx = IDX_W'(bp_index(64'(bp.BranchPCE), IDX_W));
    up_tag = TAG_W'(bp_tag(64'(bp.BranchPCE), IDX_W));
`ifdef BP_GSHARE_EN
    lk_cidx = lk_idx ^ ghr_q;
    up_cidx = up_idx ^ ghr_q;
`else
    lk_cidx = lk_idx;
    up_cidx = up_idx;
`endif
    lk_e = '{valid:  valid_q[lk_idx],
             tag:    tag_q[lk_idx],
             target: target_q[lk_idx],
             cnt:    cnt_val[lk_cidx]};
    up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_target = target_q[up_idx];
  end

  always_comb begin
    bp.hit             = lk_e.valid && (lk_e.tag == lk_tag);
    bp.BranchPredicted = bp.hit && lk_e.cnt[CNT_W-1];
    bp.currentBTA      = bp.hit ? lk_e.target : '0;
    bp.mispredictE     = bp.BranchE &&
                         ((bp.BranchPredictedE != bp.BranchTakenE) ||
                          (bp.BranchPredictedE && bp.BranchTakenE && (up_target != bp.ALUResultE)));
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_inc  = '0;
    cnt_dec  = '0;
    cnt_load = '0;
    if (bp.BranchE) begin
      if (up_hit) begin
        if (bp.BranchTakenE) begin
          cnt_inc[up_cidx]  = 1'b1;
          target_d[up_idx]  = bp.ALUResultE;
        end else begin
          cnt_dec[up_cidx]  = 1'b1;
        end
      end else if (bp.BranchTakenE) begin
        valid_d[up_idx]   = 1'b1;
        tag_d[up_idx]     = up_tag;
        target_d[up_idx]  = bp.ALUResultE;
        cnt_load[up_cidx] = 1'b1;
      end
    end
    // Flush clears valid bits even for an entry allocated in the same cycle.
    if (bp.flush_bp) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // NOTE: tags and targets have no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    sat_counter #(.W(CNT_W), .RST_VAL(CNT_WEAK_NT)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (cnt_inc[i]),
      .dec      (cnt_dec[i]),
      .load     (cnt_load[i]),
      .load_val (CNT_WEAK_T),
      .q        (cnt_val[i])
    );
  end

  sat_counter #(.W(STAT_W), .RST_VAL('0)) u_branch_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (bp.BranchE),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .q        (bp.branch_cnt)
  );

  sat_counter #(.W(STAT_W), .RST_VAL('0)) u_mispred_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (bp.mispredictE),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .q        (bp.mispred_cnt)
  );
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized bench for branch_predictor_bht against a table model built from the
// predictor rules; also runs the directed scenarios (alias, saturation, flush, reset).
module tb_branch_predictor_bht;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int STAT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_bht_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bp_if ();

  branch_predictor_bht #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain arrays and integers.
  bit          m_valid   [ENTRIES];
  int unsigned m_tag     [ENTRIES];
  logic [31:0] m_target  [ENTRIES];
  bit          m_written [ENTRIES];
  int          m_cnt     [ENTRIES];
  int          m_ghr;
  int          m_bcnt, m_mcnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic int cidx_of(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return idx_of(pc) ^ m_ghr;
`else
    return idx_of(pc);
`endif
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[cidx_of(pc)] >= (1 << (CNT_W - 1)));
  endfunction

  function automatic bit m_mispred(input bit be, input bit pe, input bit te,
                                   input logic [31:0] bpc, input logic [31:0] alu);
    return be && ((pe != te) || (pe && te && (m_target[idx_of(bpc)] != alu)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = (1 << (CNT_W - 1)) - 1;
    end
    m_ghr  = 0;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic model_edge(input bit r, input bit fl, input bit be, input bit pe, input bit te,
                            input logic [31:0] bpc, input logic [31:0] alu);
    int i, ci;
    bit h;
    if (r) begin
      model_reset();
      return;
    end
    if (be) begin
      i  = idx_of(bpc);
      ci = cidx_of(bpc);
      h  = m_hit(bpc);
      if (m_bcnt < STAT_MAX) m_bcnt++;
      if (m_mispred(be, pe, te, bpc, alu) && m_mcnt < STAT_MAX) m_mcnt++;
      if (h) begin
        if (te) begin
          if (m_cnt[ci] < CNT_MAX) m_cnt[ci]++;
          m_target[i] = alu;
        end else if (m_cnt[ci] > 0) begin
          m_cnt[ci]--;
        end
      end else if (te) begin
        m_valid[i]   = 1'b1;
        m_tag[i]     = tag_of(bpc);
        m_target[i]  = alu;
        m_written[i] = 1'b1;
        m_cnt[ci]    = 1 << (CNT_W - 1);
      end
      m_ghr = ((m_ghr << 1) | int'(te)) % ENTRIES;
    end
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end
  endtask

  // Drive one cycle (called at posedge+1), check outputs at the negedge, then
  // advance the model past the next posedge.
  task automatic cycle(input bit r, input bit fl, input bit be, input bit pe, input bit te,
                       input logic [31:0] bpc, input logic [31:0] alu, input logic [31:0] pc);
    rst                       = r;
    bp_if.flush_bp            = fl;
    bp_if.BranchE             = be;
    bp_if.BranchPredictedE    = pe;
    bp_if.BranchTakenE        = te;
    bp_if.BranchPCE           = bpc;
    bp_if.ALUResultE          = alu;
    bp_if.currentPC           = pc;
    @(negedge clk);
    check("hit",         64'(bp_if.hit),             64'(m_hit(pc)));
    check("pred",        64'(bp_if.BranchPredicted), 64'(m_pred(pc)));
    check("bta",         64'(bp_if.currentBTA),      m_hit(pc) ? 64'(m_target[idx_of(pc)]) : 64'd0);
    check("mispredictE", 64'(bp_if.mispredictE),     64'(m_mispred(be, pe, te, bpc, alu)));
    check("branch_cnt",  64'(bp_if.branch_cnt),      64'(m_bcnt));
    check("mispred_cnt", 64'(bp_if.mispred_cnt),     64'(m_mcnt));
    @(posedge clk);
    #1;
    model_edge(r, fl, be, pe, te, bpc, alu);
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'(($urandom_range(4, 6) << 6) | ($urandom_range(0, ENTRIES - 1) << 2));
  endfunction

  // Random branch; the carried prediction is usually the model's own, sometimes
  // flipped, and is only 1 where the stored target is known.
  task automatic rand_cycle(input bit r, input bit fl, input bit be);
    logic [31:0] bpc, alu;
    bit pe, te;
    bpc = rand_pc();
    alu = 32'($urandom_range(1, 4)) << 8;
    te  = 1'($urandom_range(0, 1));
    pe  = m_pred(bpc);
    if ($urandom_range(0, 3) == 0) pe = !pe;
    if (pe && !m_written[idx_of(bpc)]) pe = 1'b0;
    cycle(r, fl, be, pe, te, bpc, alu, rand_pc());
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      m_written[i] = 1'b0;
      m_target[i]  = '0;
      m_tag[i]     = 0;
    end
    rst = 1'b1;
    bp_if.flush_bp = 1'b0;  bp_if.BranchE = 1'b0;  bp_if.BranchPredictedE = 1'b0;
    bp_if.BranchTakenE = 1'b0;  bp_if.BranchPCE = '0;  bp_if.ALUResultE = '0;
    bp_if.currentPC = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then allocate 0x100 taken from a not-taken prediction.
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h100);
    cycle(0, 0, 1, 0, 1, 32'h100, 32'h200, 32'h100);
    check("alloc_hit", 64'(bp_if.hit), 64'd1);
    check("alloc_bta", 64'(bp_if.currentBTA), 64'h200);
    check("alloc_mispred_cnt", 64'(bp_if.mispred_cnt), 64'd1);

    // Not-taken three times: counter walks down and saturates at 0.
    cycle(0, 0, 1, m_pred(32'h100), 0, 32'h100, 32'h0, 32'h100);
    cycle(0, 0, 1, m_pred(32'h100), 0, 32'h100, 32'h0, 32'h100);
    cycle(0, 0, 1, m_pred(32'h100), 0, 32'h100, 32'h0, 32'h100);
    check("nt_hit_kept", 64'(bp_if.hit), 64'd1);

    // Taken hit with a new target while predicted taken to the old one.
    cycle(0, 0, 1, 1, 1, 32'h100, 32'h300, 32'h100);
    check("retarget_bta", 64'(bp_if.currentBTA), 64'h300);

    // Alias: 0x140 shares index 0 with 0x100 and evicts it.
    cycle(0, 0, 1, 0, 1, 32'h140, 32'h500, 32'h100);
    check("alias_old_hit", 64'(bp_if.hit), 64'd0);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h140);
    check("alias_new_bta", 64'(bp_if.currentBTA), 64'h500);

    // Stats saturate at all-ones.
    for (int n = 0; n < 20; n++) rand_cycle(0, 0, 1);
    check("branch_cnt_sat", 64'(bp_if.branch_cnt), 64'(STAT_MAX));

    // Flush: no entry hits, stats untouched; a taken miss in the flush cycle stays invalid.
    cycle(0, 1, 1, 0, 1, 32'h180, 32'h700, 32'h140);
    check("flush_hit", 64'(bp_if.hit), 64'd0);
    check("flush_stats", 64'(bp_if.branch_cnt), 64'(STAT_MAX));
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h180);
    check("flush_alloc_hit", 64'(bp_if.hit), 64'd0);

`ifdef BP_GSHARE_EN
    cycle(0, 0, 1, 0, 1, 32'h100, 32'h200, 32'h100);
    cycle(0, 0, 1, m_pred(32'h100), 1, 32'h100, 32'h200, 32'h100);
    cycle(0, 0, 1, m_pred(32'h100), 0, 32'h100, 32'h200, 32'h100);
    check("ghr_low", 64'(dut.ghr_q[2:0]), 64'b110);
    check("ghr_model", 64'(dut.ghr_q), 64'(m_ghr));
`endif

    // Reset beats a simultaneous taken branch.
    cycle(1, 0, 1, 0, 1, 32'h100, 32'h200, 32'h100);
    rst = 1'b0;
    check("rst_hit", 64'(bp_if.hit), 64'd0);
    check("rst_branch_cnt", 64'(bp_if.branch_cnt), 64'd0);
    check("rst_mispred_cnt", 64'(bp_if.mispred_cnt), 64'd0);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 800; n++) begin
      rand_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
